// File: rtl/mmio_pkg.sv
// Shared constants, region decode and register layout for the MMIO responder.
package mmio_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LED_W  = 10;
  localparam int SW_W   = 10;

  localparam logic [ADDR_W-1:0] RAM_BASE = 8'h00;
  localparam logic [ADDR_W-1:0] LED_BASE = 8'h80;
  localparam logic [ADDR_W-1:0] SW_BASE  = 8'h90;
  localparam logic [ADDR_W-1:0] TMR_BASE = 8'hA0;

  localparam logic [1:0] TMR_LOAD_OFS  = 2'd0;
  localparam logic [1:0] TMR_COUNT_OFS = 2'd1;
  localparam logic [1:0] TMR_CTRL_OFS  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AR_BIT   = 1;
  localparam int CTRL_FLAG_BIT = 2;

  typedef enum logic [2:0] {RGN_RAM, RGN_LED, RGN_SW, RGN_TMR, RGN_NONE} region_e;

  // Timer owns only A0..A2; A3 and above fall through to the zero region.
  function automatic region_e decode(input logic [ADDR_W-1:0] a);
    region_e r;
    r = RGN_NONE;
    if (a[7] == RAM_BASE[7])                                  r = RGN_RAM;
    else if (a[7:4] == LED_BASE[7:4])                         r = RGN_LED;
    else if (a[7:4] == SW_BASE[7:4])                          r = RGN_SW;
    else if (a[7:2] == TMR_BASE[7:2] && a[1:0] != 2'd3)       r = RGN_TMR;
    return r;
  endfunction
endpackage

// File: rtl/mmio_if.sv
// Processor-side data bus: word address, write data/strobe, registered read data.
interface mmio_if;
  import mmio_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wren;
  logic [DATA_W-1:0] rd_data;

  modport master (output addr, output wr_data, output wren, input rd_data);
  modport slave  (input addr, input wr_data, input wren, output rd_data);
endinterface

// File: rtl/mmio_timer.sv
// Prescaled down-counter timer with load, control (en/auto_reload) and W1C flag.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int TMR_PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic              ctrl_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic              irq
);
  localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TMR_PRESCALE - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] count_q, count_d, load_q, load_d;
  logic              en_q, en_d, ar_q, ar_d, flag_q, flag_d;
  logic              tick, expire;

  assign tick   = en_q && (presc_q == PRE_MAX);
  assign expire = tick && (count_q == 16'd1);

  // Register writes are applied after the tick so they take priority,
  // except the flag, where a set from expiry beats a W1C.
  always_comb begin
    presc_d = (en_q && !tick) ? presc_q + PW'(1) : '0;
    count_d = count_q;
    load_d  = load_q;
    en_d    = en_q;
    ar_d    = ar_q;
    flag_d  = flag_q;
    if (tick && count_q > 16'd1) count_d = count_q - 16'd1;
    if (expire) begin
      if (ar_q) count_d = load_q;
      else begin
        count_d = '0;
        en_d    = 1'b0;
      end
    end
    if (load_we) begin
      load_d  = wdata;
      count_d = wdata;
      presc_d = '0;
    end
    if (ctrl_we) begin
      en_d = wdata[CTRL_EN_BIT];
      ar_d = wdata[CTRL_AR_BIT];
      if (wdata[CTRL_FLAG_BIT]) flag_d = 1'b0;
    end
    if (expire) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      load_q  <= '0;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      load_q  <= load_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      flag_q  <= flag_d;
    end
  end

  assign load_o  = load_q;
  assign count_o = count_q;
  assign ctrl_o  = {13'b0, flag_q, ar_q, en_q};
  assign irq     = flag_q;
endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: RAM, LED register, synchronised switches and optional timer.
// Timer is built only when MMIO_TIMER_EN is defined.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int TMR_PRESCALE   = 50000,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic            clk_50MHz,
  input  logic            reset_n,
  mmio_if.slave           bus,
  input  logic [SW_W-1:0] sw_in,
  output logic [LED_W-1:0] led,
  output logic            timer_irq
);
  region_e rgn;
  assign rgn = decode(bus.addr);

  logic [DATA_W-1:0] ram_q [128];
  logic [DATA_W-1:0] rd_data_q, rd_data_d, tmr_rd;
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [SW_W-1:0]   sw_sync;

  // RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk_50MHz) begin
    if (bus.wren && rgn == RGN_RAM) ram_q[bus.addr[6:0]] <= bus.wr_data;
  end

  assign sw_sync = sw_sync_q[SW_SYNC_STAGES-1];

`ifdef MMIO_TIMER_EN
  logic [DATA_W-1:0] tmr_load, tmr_count, tmr_ctrl;
  logic              tmr_load_we, tmr_ctrl_we;

  assign tmr_load_we = bus.wren && rgn == RGN_TMR && bus.addr[1:0] == TMR_LOAD_OFS;
  assign tmr_ctrl_we = bus.wren && rgn == RGN_TMR && bus.addr[1:0] == TMR_CTRL_OFS;

  mmio_timer #(.TMR_PRESCALE(TMR_PRESCALE)) u_timer (
    .clk     (clk_50MHz),
    .rst_n   (reset_n),
    .load_we (tmr_load_we),
    .ctrl_we (tmr_ctrl_we),
    .wdata   (bus.wr_data),
    .load_o  (tmr_load),
    .count_o (tmr_count),
    .ctrl_o  (tmr_ctrl),
    .irq     (timer_irq)
  );

  always_comb begin
    tmr_rd = '0;
    case (bus.addr[1:0])
      TMR_LOAD_OFS:  tmr_rd = tmr_load;
      TMR_COUNT_OFS: tmr_rd = tmr_count;
      TMR_CTRL_OFS:  tmr_rd = tmr_ctrl;
      default:       tmr_rd = '0;
    endcase
  end
`else
  assign tmr_rd    = '0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    led_d     = led_q;
    sw_sync_d = {sw_sync_q[SW_SYNC_STAGES-2:0], sw_in};
    if (bus.wren && rgn == RGN_LED) led_d = bus.wr_data[LED_W-1:0];
    // Read mux sees pre-edge state, so a same-address write returns old data.
    case (rgn)
      RGN_RAM: rd_data_d = ram_q[bus.addr[6:0]];
      RGN_LED: rd_data_d = {6'b0, led_q};
      RGN_SW:  rd_data_d = {6'b0, sw_sync};
      RGN_TMR: rd_data_d = tmr_rd;
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
      led_q     <= '0;
      sw_sync_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      led_q     <= led_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign led         = led_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: directed scenarios plus random accesses
// checked against an address-map reference model.
module tb_mmio_responder;
  localparam int P = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sw_in = '0;
  logic [9:0] led;
  logic       irq;

  mmio_if bus();

  mmio_responder #(.TMR_PRESCALE(P), .SW_SYNC_STAGES(S)) dut (
    .clk_50MHz (clk),
    .reset_n   (rst_n),
    .bus       (bus),
    .sw_in     (sw_in),
    .led       (led),
    .timer_irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    bit    chk;
    int    exp_rd;
    int    exp_led;
    int    exp_irq;
    string name;
  } ent_t;
  ent_t sbq[$];

  // reference model state
  int ram [128];
  bit ram_v [128];
  int m_led = 0;
  int swlog [8192];
  int t_pre = 0, t_cnt = 0, t_load = 0, t_en = 0, t_ar = 0, t_flag = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_read(input int a);
    int idx;
    if (a < 'h80) return ram[a];
    if (a < 'h90) return m_led;
    if (a < 'hA0) begin
      idx = cyc - S + 1;
      return (idx >= 0) ? swlog[idx] : 0;
    end
    if (a == 'hA0) return t_load;
    if (a == 'hA1) return t_cnt;
    if (a == 'hA2) return (t_flag << 2) | (t_ar << 1) | t_en;
    return 0;
  endfunction

  task automatic m_step(input int a, input bit we, input int wd);
`ifdef MMIO_TIMER_EN
    bit tick, fire;
    int n_pre, n_cnt, n_en, n_flag;
    tick   = (t_en == 1) && (t_pre == P - 1);
    fire   = tick && t_cnt == 1;
    n_pre  = (t_en == 1 && !tick) ? t_pre + 1 : 0;
    n_cnt  = t_cnt;
    n_en   = t_en;
    n_flag = t_flag;
    if (tick && t_cnt > 1) n_cnt = t_cnt - 1;
    if (fire) begin
      n_flag = 1;
      if (t_ar == 1) n_cnt = t_load;
      else begin n_cnt = 0; n_en = 0; end
    end
    if (we && a == 'hA0) begin t_load = wd; n_cnt = wd; n_pre = 0; end
    if (we && a == 'hA2) begin
      n_en = wd & 1;
      t_ar = (wd >> 1) & 1;
      if (((wd >> 2) & 1) == 1 && !fire) n_flag = 0;
    end
    t_pre = n_pre; t_cnt = n_cnt; t_en = n_en; t_flag = n_flag;
`endif
    if (we) begin
      if (a < 'h80) begin ram[a] = wd; ram_v[a] = 1'b1; end
      else if (a < 'h90) m_led = wd & 'h3FF;
    end
  endtask

  task automatic m_reset();
    m_led = 0;
    t_pre = 0; t_cnt = 0; t_load = 0; t_en = 0; t_ar = 0; t_flag = 0;
  endtask

  // One bus cycle; exp_ovr >= 0 pins the read result to a hand-derived value.
  task automatic do_cyc(input int a, input bit we, input int wd, input int exp_ovr,
                        input string name);
    ent_t e;
    bus.addr    = 8'(a);
    bus.wren    = we;
    bus.wr_data = 16'(wd);
    swlog[cyc+1] = int'(sw_in);
    e.due    = cyc + 1;
    e.name   = name;
    e.exp_rd = (exp_ovr >= 0) ? exp_ovr : m_read(a);
    e.chk    = !(a < 'h80 && !ram_v[a] && exp_ovr < 0);
    m_step(a, we, wd & 'hFFFF);
    e.exp_led = m_led;
    e.exp_irq = t_flag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    ent_t e;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      failures++;
      $display("FAIL %s: response slot missed (due %0d, now %0d)", e.name, e.due, cyc);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      if (e.chk) check({e.name, "_rd"}, int'(bus.rd_data), e.exp_rd);
      check({e.name, "_led"}, int'(led), e.exp_led);
      check({e.name, "_irq"}, int'(irq), e.exp_irq);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, r, wd;
    bit we;
    bus.addr = '0; bus.wren = 1'b0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd", int'(bus.rd_data), 0);
    check("reset_led", int'(led), 0);
    check("reset_irq", int'(irq), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RAM
    do_cyc('h05, 1, 'h1234, -1, "ram_wr05");
    do_cyc('h7F, 1, 'hBEEF, -1, "ram_wr7f");
    do_cyc('h05, 0, 0, 'h1234, "ram_rd05");
    do_cyc('h7F, 0, 0, 'hBEEF, "ram_rd7f");
    do_cyc('h05, 1, 'h5555, 'h1234, "ram_rdw_old");
    do_cyc('h05, 0, 0, 'h5555, "ram_rd05_new");

    // LED and switches
    do_cyc('h80, 1, 'hFFFF, -1, "led_wr");
    check("led_all_on", int'(led), 'h3FF);
    do_cyc('h8F, 0, 0, 'h03FF, "led_rd_alias");
    sw_in = 10'h2A5;
    repeat (S) do_cyc('h00, 0, 0, -1, "sw_wait");
    do_cyc('h90, 0, 0, 'h02A5, "sw_rd");
    do_cyc('h9F, 1, 'h0000, 'h02A5, "sw_wr_ignored");
    do_cyc('h90, 0, 0, 'h02A5, "sw_rd2");

    // Unmapped
    do_cyc('hC0, 1, 'h1111, 0, "unmapped_c0");
    do_cyc('hA3, 1, 'h2222, 0, "unmapped_a3");
    do_cyc('hFF, 0, 0, 0, "unmapped_ff");

`ifdef MMIO_TIMER_EN
    // One-shot: load 3, enable; flag after 3*P cycles
    do_cyc('hA0, 1, 3, -1, "os_load");
    do_cyc('hA2, 1, 1, -1, "os_ctrl");
    n = 0;
    while (irq !== 1'b1 && n < 40) begin
      do_cyc('hA2, 0, 0, -1, "os_poll");
      n++;
    end
    check("os_irq_latency", n, 12);
    do_cyc('hA2, 0, 0, 'h4, "os_ctrl_rd");
    do_cyc('hA1, 0, 0, 0, "os_count_rd");
    do_cyc('hA2, 1, 'h4, 'h4, "os_w1c");
    check("os_irq_cleared", int'(irq), 0);
    do_cyc('hA2, 0, 0, 0, "os_ctrl_after_w1c");

    // Auto-reload: load 2, flag every 2*P cycles
    do_cyc('hA0, 1, 2, -1, "ar_load");
    do_cyc('hA2, 1, 3, -1, "ar_ctrl");
    for (int k = 1; k <= 24; k++) begin
      if (k == 10 || k == 16) do_cyc('hA2, 1, 7, -1, "ar_w1c");
      else if (k == 20)       do_cyc('hA0, 1, 2, -1, "ar_load_vs_tick");
      else                    do_cyc('hA1, 0, 0, -1, "ar_count");
      if (k == 7)  check("ar_irq_before", int'(irq), 0);
      if (k == 8)  check("ar_irq_set", int'(irq), 1);
      if (k == 10) check("ar_irq_w1c", int'(irq), 0);
      if (k == 16) check("ar_set_beats_w1c", int'(irq), 1);
    end
    do_cyc('hA2, 1, 4, -1, "ar_stop");
`else
    do_cyc('hA0, 1, 'h55, -1, "notmr_wr_a0");
    do_cyc('hA0, 0, 0, 0, "notmr_rd_a0");
    do_cyc('hA2, 1, 'h7, 0, "notmr_rd_a2");
`endif

    // Randomized accesses
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        4:       a = 'h80 + $urandom_range(0, 15);
        5:       a = 'h90 + $urandom_range(0, 15);
        6:       a = 'hA0 + $urandom_range(0, 2);
        7:       a = 'hA3 + $urandom_range(0, 'hFF - 'hA3);
        default: a = $urandom_range(0, 127);
      endcase
      we = ($urandom_range(0, 1) == 1);
      wd = $urandom_range(0, 'hFFFF);
      if (a == 'hA0) wd = $urandom_range(0, 5);
      if (a == 'hA2) wd = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) sw_in = 10'($urandom_range(0, 1023));
      do_cyc(a, we, wd, -1, "rand");
    end

    // Reset mid-count
    do_cyc('h80, 1, 'h155, -1, "pre_rst_led");
`ifdef MMIO_TIMER_EN
    do_cyc('hA0, 1, 1, -1, "pre_rst_load");
    do_cyc('hA2, 1, 3, -1, "pre_rst_ctrl");
    repeat (6) do_cyc('h80, 0, 0, -1, "pre_rst_run");
    check("pre_rst_irq", int'(irq), 1);
`else
    do_cyc('h80, 0, 0, -1, "pre_rst_run");
`endif
    check("pre_rst_rd", int'(bus.rd_data), 'h155);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_led", int'(led), 0);
    check("midrst_rd", int'(bus.rd_data), 0);
    check("midrst_irq", int'(irq), 0);
    m_reset();
    bus.wren = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cyc('hA1, 0, 0, 0, "post_rst_count");
    do_cyc('hA2, 0, 0, 0, "post_rst_ctrl");
    do_cyc('h80, 0, 0, 0, "post_rst_led");

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
